// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: controller states and the
// per-frame settings captured when a byte is accepted.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } uart_arb_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              parity_en;
    logic              parity_odd;
  } uart_frame_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting bit at or after the
// pointer, wrapping. Returns one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any) begin
        pos     = (int'(ptr) + i) % NUM_REQ;
        pos_idx = IDX_W'(pos);
        if (req[pos_idx]) begin
          any          = 1'b1;
          grant[pos_idx] = 1'b1;
          idx          = pos_idx;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte sources: round-robin with packet
// lock, programmable inter-frame gap and a per-frame watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_W       = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int TO_W        = 18
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      cfg_parity_en_i,
  input  logic                      cfg_parity_odd_i,
  input  logic [GAP_W-1:0]          cfg_gap_i,
  output logic                      tx_en_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  output logic                      parity_en_o,
  output logic                      parity_odd_o,
  output logic                      uart_rst_o,
  input  logic                      tx_done_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      lock_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      timeout_o
);

  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

  uart_arb_state_e    state, state_nxt;
  uart_frame_t        frame_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [TO_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               accept;
  logic               wd_hit;

  // While a packet is locked only its owner may compete.
  assign arb_req = lock_o ? (req_valid_i & grant_o) : req_valid_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign accept = (state == ST_IDLE) && arb_any;
  assign wd_hit = (state == ST_SEND) && !tx_done_i && (wd_cnt == WD_LAST);

  assign tx_data_o    = frame_q.data;
  assign parity_en_o  = frame_q.parity_en;
  assign parity_odd_o = frame_q.parity_odd;
  assign busy_o       = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx_en must fall in the tx_done cycle, otherwise uart_tx starts a new frame.
  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    tx_en_o     = 1'b0;
    uart_rst_o  = 1'b0;
    timeout_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_o = arb_grant;
          state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done_i) begin
          state_nxt = (cfg_gap_i != '0) ? ST_GAP : ST_IDLE;
        end else if (wd_hit) begin
          uart_rst_o = 1'b1;
          timeout_o  = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          tx_en_o = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q      <= '0;
      grant_o      <= '0;
      lock_o       <= 1'b0;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      gap_cnt      <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= (state == ST_SEND) && tx_done_i;
      if (accept) begin
        frame_q <= '{data:       req_data_i[arb_idx*BYTE_W +: BYTE_W],
                     parity_en:  cfg_parity_en_i,
                     parity_odd: cfg_parity_odd_i};
        grant_o <= arb_grant;
        lock_o  <= !req_last_i[arb_idx];
        rr_ptr  <= (arb_idx == IDX_MAX) ? '0 : arb_idx + IDX_W'(1);
        wd_cnt  <= '0;
      end
      if (state == ST_SEND) begin
        wd_cnt <= wd_cnt + TO_W'(1);
        if (tx_done_i) begin
          gap_cnt <= cfg_gap_i;
        end else if (wd_hit) begin
          // The abandoned packet's remaining bytes no longer own the link.
          lock_o <= 1'b0;
        end
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx responder.
module tb_uart_tx_arbiter;

  localparam int NR        = 4;
  localparam int GW        = 8;
  localparam int TOC       = 50;
  localparam int TOW       = 6;
  localparam int FRAME_LEN = 6;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NR-1:0]   req_valid_i;
  logic [NR*8-1:0] req_data_i;
  logic [NR-1:0]   req_last_i;
  logic [NR-1:0]   req_ready_o;
  logic            cfg_parity_en_i;
  logic            cfg_parity_odd_i;
  logic [GW-1:0]   cfg_gap_i;
  logic            tx_en_o;
  logic [7:0]      tx_data_o;
  logic            parity_en_o;
  logic            parity_odd_o;
  logic            uart_rst_o;
  logic            tx_done_i;
  logic [NR-1:0]   grant_o;
  logic            lock_o;
  logic            busy_o;
  logic            frame_done_o;
  logic            timeout_o;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .GAP_W       (GW),
    .TIMEOUT_CYC (TOC),
    .TO_W        (TOW)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_data_i       (req_data_i),
    .req_last_i       (req_last_i),
    .req_ready_o      (req_ready_o),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_gap_i        (cfg_gap_i),
    .tx_en_o          (tx_en_o),
    .tx_data_o        (tx_data_o),
    .parity_en_o      (parity_en_o),
    .parity_odd_o     (parity_odd_o),
    .uart_rst_o       (uart_rst_o),
    .tx_done_i        (tx_done_i),
    .grant_o          (grant_o),
    .lock_o           (lock_o),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
    logic       pen;
    logic       podd;
    int         acc;
  } exp_t;

  byte_t rq[NR][$];
  exp_t  sb[$];
  exp_t  cur;
  int    acc_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit pause[NR];
  bit mute, wd_test, gap_chk, mon_en;
  int mdl_ptr, mdl_owner;
  bit mdl_lock;
  int done_cyc, gap_v, first_acc;
  bit have_done, prev_en, done_prev;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_winner(input logic [NR-1:0] v);
    logic [NR-1:0] c;
    int k;
    c = mdl_lock ? (v & NR'(1 << mdl_owner)) : v;
    for (int i = 0; i < NR; i++) begin
      k = (mdl_ptr + i) % NR;
      if (c[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) return 1'b0;
    return (sb.size() == 0);
  endfunction

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (!(all_empty() && !busy_o && !tx_en_o) && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_idle_budget", n < lim, 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic wait_tx_en(input int lim);
    int n;
    n = 0;
    while (!tx_en_o && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    check("tx_en_budget", n < lim, 1);
  endtask

  // Requester driver: offers queue heads, records accepts into the scoreboard.
  initial begin
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    forever begin
      int   w, a;
      exp_t e;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (rq[k].size() > 0 && !pause[k]) begin
          req_valid_i[k]         = 1'b1;
          req_data_i[8*k +: 8]   = rq[k][0].data;
          req_last_i[k]          = rq[k][0].last;
        end else begin
          req_valid_i[k]         = 1'b0;
          req_data_i[8*k +: 8]   = 8'h00;
          req_last_i[k]          = 1'b0;
        end
      end
      @(negedge clk_i);
      if (rst_ni && req_ready_o != '0) begin
        w = exp_winner(req_valid_i);
        a = -1;
        for (int k = NR - 1; k >= 0; k--) if (req_ready_o[k]) a = k;
        check("ready_grant", req_ready_o, (w >= 0) ? (32'(1) << w) : 32'(0));
        if (a >= 0 && rq[a].size() > 0) begin
          e.idx  = a;
          e.data = rq[a][0].data;
          e.last = rq[a][0].last;
          e.pen  = cfg_parity_en_i;
          e.podd = cfg_parity_odd_i;
          e.acc  = cyc;
          sb.push_back(e);
          void'(rq[a].pop_front());
          if (gap_chk && have_done) check("gap_cycles", cyc - done_cyc, gap_v + 1);
          have_done = 1'b0;
          mdl_ptr   = (a + 1) % NR;
          mdl_lock  = !e.last;
          mdl_owner = a;
          acc_log.push_back(a);
          if (first_acc < 0) first_acc = a;
        end
      end
    end
  end

  // uart_tx responder: tx_done one cycle after FRAME_LEN cycles of tx_en.
  initial begin
    int u_cnt;
    u_cnt     = 0;
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!tx_en_o) u_cnt = 0;
      else if (!mute) u_cnt++;
      if (u_cnt == FRAME_LEN) begin
        @(posedge clk_i);
        #1 tx_done_i = 1'b1;
        @(posedge clk_i);
        #1 tx_done_i = 1'b0;
        u_cnt = 0;
      end
    end
  end

  // Output monitor: frame start, done handling, pulse timing.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && mon_en) begin
        if (tx_en_o && !prev_en) begin
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("tx_data", tx_data_o, cur.data);
            check("tx_grant", grant_o, 32'(1) << cur.idx);
            check("tx_par_en", parity_en_o, cur.pen);
            check("tx_par_odd", parity_odd_o, cur.podd);
            check("tx_lock", lock_o, !cur.last);
            check("acc_latency", cyc - cur.acc, 1);
          end
        end
        if (tx_done_i) begin
          check("tx_en_gate", tx_en_o, 0);
          check("data_hold", tx_data_o, cur.data);
          done_cyc  = cyc;
          gap_v     = int'(cfg_gap_i);
          have_done = 1'b1;
        end
        check("frame_done", frame_done_o, done_prev);
        if (timeout_o) begin
          mdl_lock  = 1'b0;
          have_done = 1'b0;
          if (!wd_test) check("spurious_timeout", timeout_o, 0);
        end
        if (req_ready_o != '0 && busy_o) check("ready_while_busy", req_ready_o, 0);
      end
      prev_en   = tx_en_o;
      done_prev = tx_done_i && rst_ni;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit got=%0d exp=finished", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int rr_exp[5];
    int lk_exp[4];
    rr_exp = '{0, 1, 2, 3, 0};
    lk_exp = '{1, 1, 1, 2};
    rst_ni           = 1'b0;
    cfg_parity_en_i  = 1'b0;
    cfg_parity_odd_i = 1'b0;
    cfg_gap_i        = '0;
    mute = 0; wd_test = 0; gap_chk = 0; mon_en = 0;
    mdl_ptr = 0; mdl_owner = 0; mdl_lock = 0;
    have_done = 0; first_acc = -1;
    for (int k = 0; k < NR; k++) pause[k] = 1'b0;

    repeat (3) @(negedge clk_i);
    check("rst_tx_en", tx_en_o, 0);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_ready", req_ready_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_lock", lock_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_uart_rst", uart_rst_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_parity", {parity_en_o, parity_odd_o}, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    mon_en = 1;

    // Round robin, gap 0
    acc_log.delete();
    have_done = 0;
    gap_chk   = 1;
    rq[0].push_back('{8'h11, 1'b1});
    rq[0].push_back('{8'h15, 1'b1});
    rq[1].push_back('{8'h22, 1'b1});
    rq[2].push_back('{8'h33, 1'b1});
    rq[3].push_back('{8'h44, 1'b1});
    wait_idle(300);
    gap_chk = 0;
    check("rr_count", acc_log.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), (i < acc_log.size()) ? acc_log[i] : -1, rr_exp[i]);

    // Single byte
    acc_log.delete();
    rq[0].push_back('{8'hA5, 1'b1});
    wait_idle(100);
    check("single_lock", lock_o, 0);
    check("single_count", acc_log.size(), 1);

    // Inter-frame gap of 3, odd parity
    cfg_gap_i        = 8'd3;
    cfg_parity_en_i  = 1'b1;
    cfg_parity_odd_i = 1'b1;
    have_done = 0;
    gap_chk   = 1;
    rq[0].push_back('{8'h01, 1'b1});
    rq[0].push_back('{8'h02, 1'b1});
    rq[0].push_back('{8'h03, 1'b1});
    wait_idle(200);
    gap_chk          = 0;
    cfg_gap_i        = 8'd0;
    cfg_parity_odd_i = 1'b0;

    // Packet lock with a valid gap on the owner
    acc_log.delete();
    rq[1].push_back('{8'hB0, 1'b0});
    rq[1].push_back('{8'hB1, 1'b0});
    rq[1].push_back('{8'hB2, 1'b1});
    rq[2].push_back('{8'hC0, 1'b1});
    n = 0;
    while (rq[1].size() != 2 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("lock_first_budget", n < 50, 1);
    pause[1] = 1'b1;
    repeat (20) @(negedge clk_i);
    check("lock_req2_waiting", rq[2].size(), 1);
    check("lock_held", lock_o, 1);
    check("lock_owner", grant_o, 4'b0010);
    check("lock_idle_wait", busy_o, 0);
    pause[1] = 1'b0;
    wait_idle(300);
    check("lock_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("lock_order%0d", i), (i < acc_log.size()) ? acc_log[i] : -1, lk_exp[i]);
    cfg_parity_en_i = 1'b0;

    // Watchdog: uart_tx never answers
    acc_log.delete();
    mute    = 1;
    wd_test = 1;
    rq[0].push_back('{8'hD0, 1'b0});
    wait_tx_en(20);
    n = 1;
    while (!timeout_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("wd_cycle", n, TOC);
    check("wd_uart_rst", uart_rst_o, 1);
    check("wd_tx_en", tx_en_o, 0);
    mute = 0;
    rq[3].push_back('{8'hE3, 1'b1});
    @(negedge clk_i);
    check("wd_lock_clear", lock_o, 0);
    check("wd_uart_rst_pulse", uart_rst_o, 0);
    wd_test = 0;
    wait_idle(100);
    check("wd_count", acc_log.size(), 2);
    check("wd_next_grant", (acc_log.size() > 1) ? acc_log[1] : -1, 3);

    // Asynchronous reset mid-frame
    rq[2].push_back('{8'hF2, 1'b1});
    wait_tx_en(20);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    mon_en = 0;
    #1;
    check("arst_tx_en", tx_en_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_grant", grant_o, 0);
    mdl_ptr = 0; mdl_lock = 0; have_done = 0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    mon_en    = 1;
    acc_log.delete();
    first_acc = -1;
    rq[3].push_back('{8'h3C, 1'b1});
    rq[0].push_back('{8'h0C, 1'b1});
    wait_idle(200);
    check("arst_first_grant", first_acc, 0);
    check("arst_count", acc_log.size(), 2);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
